// File: rtl/ec_pkg.sv
// Shared widths, FSM state encoding and job payload for the EC_TOP host sequencer.
package ec_pkg;

    localparam int unsigned EC_W  = 6;
    localparam int unsigned LAT_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } ec_state_e;

    typedef struct packed {
        logic [EC_W-1:0] px;
        logic [EC_W-1:0] py;
        logic [EC_W-1:0] qx;
        logic [EC_W-1:0] qy;
        logic [EC_W-1:0] prime;
        logic [EC_W-1:0] a;
    } ec_job_t;

endpackage

// File: rtl/ec_host_timer.sv
// Wait counter with timeout compare and optional saturating issue-to-result latency counter.
// Latency counter is built only when EC_HOST_LATCNT_EN is defined; otherwise lat_c_o is 0.
module ec_host_timer
    import ec_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic             at_limit_c_o,
    output logic [LAT_W-1:0] lat_c_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    assign at_limit_c_o = (cnt_q == CNT_MAX);

    // Stops at the limit so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !at_limit_c_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef EC_HOST_LATCNT_EN
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    logic [LAT_W-1:0] lat_q;

    // Starts at 1 so the value seen in a WAIT cycle is already counter+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q <= '0;
        end else if (clr_i) begin
            lat_q <= LAT_W'(1);
        end else if (inc_i && (lat_q != LAT_MAX)) begin
            lat_q <= lat_q + LAT_W'(1);
        end
    end

    assign lat_c_o = lat_q;
`else
    assign lat_c_o = '0;
`endif

endmodule

// File: rtl/ec_host_if.sv
// Host sequencer for EC_TOP: one job in flight, timeout detection, sticky spurious-response flag.
// Optional latency reporting is enabled by defining EC_HOST_LATCNT_EN.
module ec_host_if
    import ec_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [EC_W-1:0]  job_Px,
    input  logic [EC_W-1:0]  job_Py,
    input  logic [EC_W-1:0]  job_Qx,
    input  logic [EC_W-1:0]  job_Qy,
    input  logic [EC_W-1:0]  job_prime,
    input  logic [EC_W-1:0]  job_a,
    output logic             ec_in_valid,
    output logic [EC_W-1:0]  ec_in_Px,
    output logic [EC_W-1:0]  ec_in_Py,
    output logic [EC_W-1:0]  ec_in_Qx,
    output logic [EC_W-1:0]  ec_in_Qy,
    output logic [EC_W-1:0]  ec_in_prime,
    output logic [EC_W-1:0]  ec_in_a,
    input  logic             ec_out_valid,
    input  logic [EC_W-1:0]  ec_out_Rx,
    input  logic [EC_W-1:0]  ec_out_Ry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [EC_W-1:0]  res_Rx,
    output logic [EC_W-1:0]  res_Ry,
    output logic             res_timeout,
    output logic [LAT_W-1:0] res_lat,
    output logic             spurious_err
);

    ec_state_e        state_q;
    ec_job_t          ec_in_q;
    logic             job_ready_q;
    logic             ec_in_valid_q;
    logic             res_valid_q;
    logic [EC_W-1:0]  res_rx_q;
    logic [EC_W-1:0]  res_ry_q;
    logic             res_timeout_q;
    logic [LAT_W-1:0] res_lat_q;
    logic             spurious_q;
    logic             at_limit_c;
    logic [LAT_W-1:0] lat_c;
    ec_job_t          job_in;

    assign job_in = '{px: job_Px, py: job_Py, qx: job_Qx, qy: job_Qy,
                      prime: job_prime, a: job_a};

    ec_host_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (state_q == ISSUE),
        .inc_i        (state_q == WAIT),
        .at_limit_c_o (at_limit_c),
        .lat_c_o      (lat_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ec_in_q       <= '0;
            job_ready_q   <= 1'b0;
            ec_in_valid_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_rx_q      <= '0;
            res_ry_q      <= '0;
            res_timeout_q <= 1'b0;
            res_lat_q     <= '0;
            spurious_q    <= 1'b0;
        end else begin
            if (ec_out_valid && (state_q != WAIT)) begin
                spurious_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    // job_ready_q is low for the first cycle after reset release.
                    job_ready_q <= 1'b1;
                    if (job_valid && job_ready_q) begin
                        ec_in_q       <= job_in;
                        ec_in_valid_q <= 1'b1;
                        job_ready_q   <= 1'b0;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    ec_in_q       <= '0;
                    ec_in_valid_q <= 1'b0;
                    state_q       <= WAIT;
                end
                WAIT: begin
                    // A response on the final WAIT cycle takes priority over the timeout.
                    if (ec_out_valid) begin
                        res_rx_q      <= ec_out_Rx;
                        res_ry_q      <= ec_out_Ry;
                        res_timeout_q <= 1'b0;
                        res_lat_q     <= lat_c;
                        res_valid_q   <= 1'b1;
                        state_q       <= HOLD;
                    end else if (at_limit_c) begin
                        res_rx_q      <= '0;
                        res_ry_q      <= '0;
                        res_timeout_q <= 1'b1;
                        res_lat_q     <= lat_c;
                        res_valid_q   <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        job_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign job_ready    = job_ready_q;
    assign ec_in_valid  = ec_in_valid_q;
    assign ec_in_Px     = ec_in_q.px;
    assign ec_in_Py     = ec_in_q.py;
    assign ec_in_Qx     = ec_in_q.qx;
    assign ec_in_Qy     = ec_in_q.qy;
    assign ec_in_prime  = ec_in_q.prime;
    assign ec_in_a      = ec_in_q.a;
    assign res_valid    = res_valid_q;
    assign res_Rx       = res_rx_q;
    assign res_Ry       = res_ry_q;
    assign res_timeout  = res_timeout_q;
    assign res_lat      = res_lat_q;
    assign spurious_err = spurious_q;

endmodule

// File: tb/tb_ec_host_if.sv
// Self-checking bench for ec_host_if: scoreboard of expected results, bench-driven core responses.
module tb_ec_host_if;

    localparam int unsigned T = 8;
`ifdef EC_HOST_LATCNT_EN
    localparam bit LAT_ON = 1'b1;
`else
    localparam bit LAT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [5:0] rx;
        logic [5:0] ry;
        logic       to;
        logic [9:0] lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       job_valid, job_ready;
    logic [5:0] job_Px, job_Py, job_Qx, job_Qy, job_prime, job_a;
    logic       ec_in_valid;
    logic [5:0] ec_in_Px, ec_in_Py, ec_in_Qx, ec_in_Qy, ec_in_prime, ec_in_a;
    logic       ec_out_valid;
    logic [5:0] ec_out_Rx, ec_out_Ry;
    logic       res_valid, res_ready;
    logic [5:0] res_Rx, res_Ry;
    logic       res_timeout;
    logic [9:0] res_lat;
    logic       spurious_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   in_pulses = 0;
    logic in_prev = 1'b0;
    exp_t sb[$];

    ec_host_if #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_Px(job_Px), .job_Py(job_Py), .job_Qx(job_Qx), .job_Qy(job_Qy),
        .job_prime(job_prime), .job_a(job_a),
        .ec_in_valid(ec_in_valid),
        .ec_in_Px(ec_in_Px), .ec_in_Py(ec_in_Py), .ec_in_Qx(ec_in_Qx), .ec_in_Qy(ec_in_Qy),
        .ec_in_prime(ec_in_prime), .ec_in_a(ec_in_a),
        .ec_out_valid(ec_out_valid), .ec_out_Rx(ec_out_Rx), .ec_out_Ry(ec_out_Ry),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_Rx(res_Rx), .res_Ry(res_Ry), .res_timeout(res_timeout), .res_lat(res_lat),
        .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] lat_exp(input int n);
        return LAT_ON ? 10'(n) : 10'd0;
    endfunction

    // Issue-pulse monitor and result scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_prev) chk_eq("in_valid_gap", 64'(ec_in_valid), 64'd0);
            if (ec_in_valid) in_pulses++;
            in_prev = ec_in_valid;
            if (res_valid && res_ready) begin
                chk_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_eq("res", 64'({res_Rx, res_Ry, res_timeout, res_lat}), 64'(e));
                end
            end
        end else begin
            in_prev = 1'b0;
        end
    end

    task automatic drive_job(input logic [5:0] px, py, qx, qy, pr, aa);
        @(negedge clk);
        chk_eq("job_ready_idle", 64'(job_ready), 64'd1);
        job_valid = 1'b1;
        job_Px = px; job_Py = py; job_Qx = qx; job_Qy = qy; job_prime = pr; job_a = aa;
        @(posedge clk);
        #1 job_valid = 1'b0;
        chk_eq("issue_valid", 64'(ec_in_valid), 64'd1);
        chk_eq("issue_ops", 64'({ec_in_Px, ec_in_Py, ec_in_Qx, ec_in_Qy, ec_in_prime, ec_in_a}),
               64'({px, py, qx, qy, pr, aa}));
    endtask

    // Core model: dly>0 responds in cycle issue+dly, dly==0 never responds.
    task automatic respond(input int dly, input logic [5:0] rx, ry);
        if (dly == 0) begin
            for (int i = 1; i <= int'(T); i++) begin
                @(posedge clk); #1;
                chk_eq("to_not_early", 64'(res_valid), 64'd0);
            end
            @(posedge clk); #1;
            chk_eq("to_rise", 64'(res_valid), 64'd1);
        end else begin
            repeat (dly) @(posedge clk);
            #1 ec_out_valid = 1'b1; ec_out_Rx = rx; ec_out_Ry = ry;
            @(posedge clk);
            #1 ec_out_valid = 1'b0; ec_out_Rx = '0; ec_out_Ry = '0;
            chk_eq("res_rise", 64'(res_valid), 64'd1);
        end
    endtask

    task automatic run_job(input logic [5:0] px, py, qx, qy, pr, aa,
                           input int dly, input logic [5:0] rx, ry);
        exp_t e;
        if (dly == 0) e = '{rx: 6'd0, ry: 6'd0, to: 1'b1, lat: lat_exp(int'(T))};
        else          e = '{rx: rx, ry: ry, to: 1'b0, lat: lat_exp(dly)};
        sb.push_back(e);
        drive_job(px, py, qx, qy, pr, aa);
        respond(dly, rx, ry);
    endtask

    task automatic post_idle();
        @(posedge clk); #1;
        chk_eq("res_drop", 64'(res_valid), 64'd0);
        chk_eq("idle_ready", 64'(job_ready), 64'd1);
        chk_eq("ops_zero", 64'({ec_in_Px, ec_in_Py, ec_in_Qx, ec_in_Qy, ec_in_prime, ec_in_a}), 64'd0);
    endtask

    initial begin
        int p0;
        exp_t bp;
        job_valid = 1'b0;
        job_Px = '0; job_Py = '0; job_Qx = '0; job_Qy = '0; job_prime = '0; job_a = '0;
        ec_out_valid = 1'b0; ec_out_Rx = '0; ec_out_Ry = '0;
        res_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_eq("rst_job_ready", 64'(job_ready), 64'd0);
        chk_eq("rst_outs", 64'({ec_in_valid, res_valid, res_timeout, spurious_err, res_lat}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_eq("rel_job_ready", 64'(job_ready), 64'd1);

        // Single job
        p0 = in_pulses;
        run_job(6'd5, 6'd1, 6'd5, 6'd1, 6'd17, 6'd2, 3, 6'd6, 6'd3);
        post_idle();
        chk_eq("single_pulses", 64'(in_pulses - p0), 64'd1);

        // Backpressure with a second job offered while holding
        p0 = in_pulses;
        res_ready = 1'b0;
        bp = '{rx: 6'd7, ry: 6'd9, to: 1'b0, lat: lat_exp(2)};
        sb.push_back(bp);
        drive_job(6'd3, 6'd4, 6'd10, 6'd11, 6'd13, 6'd1);
        respond(2, 6'd7, 6'd9);
        job_valid = 1'b1; job_Px = 6'd33;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_eq("bp_hold", 64'({res_valid, res_Rx, res_Ry, res_timeout, res_lat, job_ready}),
                   64'({1'b1, bp.rx, bp.ry, bp.to, bp.lat, 1'b0}));
        end
        @(posedge clk);
        #1 job_valid = 1'b0; res_ready = 1'b1;
        post_idle();
        chk_eq("bp_pulses", 64'(in_pulses - p0), 64'd1);

        // Timeout, then a late response flags spurious_err
        run_job(6'd2, 6'd2, 6'd2, 6'd2, 6'd23, 6'd0, 0, 6'd0, 6'd0);
        post_idle();
        chk_eq("spur_clear", 64'(spurious_err), 64'd0);
        #0 ec_out_valid = 1'b1; ec_out_Rx = 6'd63; ec_out_Ry = 6'd63;
        @(posedge clk);
        #1 ec_out_valid = 1'b0;
        chk_eq("spur_set", 64'(spurious_err), 64'd1);
        chk_eq("spur_no_res", 64'(res_valid), 64'd0);

        // Response on the last WAIT cycle
        run_job(6'd9, 6'd8, 6'd7, 6'd6, 6'd29, 6'd3, int'(T), 6'd12, 6'd34);
        post_idle();

        // Back-to-back jobs at minimum spacing
        run_job(6'd1, 6'd2, 6'd3, 6'd4, 6'd31, 6'd5, 1, 6'd40, 6'd41);
        post_idle();
        run_job(6'd4, 6'd3, 6'd2, 6'd1, 6'd37, 6'd6, 1, 6'd42, 6'd43);
        post_idle();

        // Asynchronous reset mid-WAIT
        drive_job(6'd5, 6'd5, 6'd5, 6'd5, 6'd41, 6'd7);
        @(posedge clk);
        #3 rst_n = 1'b0;
        sb.delete();
        #1;
        chk_eq("mid_rst_outs", 64'({res_valid, ec_in_valid, job_ready, spurious_err}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk_eq("mid_rel_ready0", 64'(job_ready), 64'd0);
        @(posedge clk); #1;
        chk_eq("mid_rel_ready1", 64'(job_ready), 64'd1);

        // Normal operation after reset
        run_job(6'd5, 6'd1, 6'd5, 6'd1, 6'd17, 6'd2, 3, 6'd6, 6'd3);
        post_idle();
        chk_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ec_host_if.md
# ec_host_if

Host-side sequencer for the EC_TOP point-operation core: it accepts operand jobs (Px, Py, Qx, Qy, prime, a) over a valid/ready port and issues each one to EC_TOP as a single-cycle `in_valid` pulse. It then waits for the matching `out_valid` pulse and presents the result (Rx, Ry) on a valid/ready result port. It sits between a job source (bus bridge or FIFO) and one EC_TOP instance, guaranteeing one job in flight, detecting timeouts and flagging protocol violations from the core.

## Interface
- TIMEOUT_CYC, 1000, max WAIT cycles before a job is abandoned (≥1)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  high only in IDLE; reset 0
- job_Px, job_Py, job_Qx, job_Qy, job_prime, job_a  in  6 each  job operands
- ec_in_valid  out  1  one-cycle issue pulse to EC_TOP; reset 0
- ec_in_Px, ec_in_Py, ec_in_Qx, ec_in_Qy, ec_in_prime, ec_in_a  out  6 each  registered operands, 0 outside ISSUE; reset 0
- ec_out_valid  in  1  EC_TOP result pulse
- ec_out_Rx, ec_out_Ry  in  6 each  EC_TOP result
- res_valid  out  1  result held until taken; reset 0
- res_ready  in  1  consumer accepts result
- res_Rx, res_Ry  out  6 each  captured result, 0 on timeout; reset 0
- res_timeout  out  1  result is a timeout record; reset 0
- res_lat  out  10  issue-to-result latency, saturating at 1023; reset 0
- spurious_err  out  1  sticky: ec_out_valid seen outside WAIT; reset 0, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, HOLD; reset → IDLE.
- IDLE: job_ready=1. On job_valid, latch the operands → ISSUE.
- ISSUE (exactly 1 cycle): ec_in_valid=1 with the latched operands. Clear the wait counter → WAIT.
- WAIT: the counter increments each cycle.
  - On ec_out_valid, capture Rx/Ry, set res_timeout=0 and res_lat=counter+1 → HOLD.
  - If the counter reaches TIMEOUT_CYC−1 with no ec_out_valid, set res_timeout=1 and res_Rx=res_Ry=0 → HOLD.
  - If ec_out_valid and the limit coincide, the result wins (res_timeout=0).
- HOLD: res_valid=1 and all res_* fields are stable. On res_ready → IDLE, and res_valid drops the next cycle.
- ec_out_valid in IDLE, ISSUE or HOLD is ignored for data and sets spurious_err. This also covers a late response after a timeout.
- No back-to-back issue: at least one IDLE cycle separates jobs, so ec_in_valid is never asserted on adjacent cycles.
- Reset mid-job: all outputs go to their reset values immediately (asynchronous). The pending job and result are lost, and the state returns to IDLE.
- The counter is wide enough for TIMEOUT_CYC and never wraps.

## Timing
- Job handshake at edge k → ec_in_valid high in cycle k+1.
- ec_in_valid in cycle c, ec_out_valid in cycle c+n → res_valid from cycle c+n+1 with res_lat=n.
- Timeout: res_valid rises TIMEOUT_CYC+1 cycles after the ec_in_valid cycle.
- Minimum job-to-job spacing: 4 cycles with a 1-cycle core response and res_ready held high.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- EC_HOST_LATCNT_EN defined: res_lat is driven as described above.
- EC_HOST_LATCNT_EN undefined: the latency register is not built and res_lat is tied to 0. The port list is identical in both builds. Timeout detection is always present.

## Structure
- Package ec_pkg:
  - EC_W=6
  - LAT_W=10
  - state enum (IDLE/ISSUE/WAIT/HOLD)
  - packed job struct (Px, Py, Qx, Qy, prime, a)
- Sub-module ec_host_timer holds the wait counter, the timeout compare, and the optional saturating latency counter.
- The top-level FSM and datapath registers stay in ec_host_if.

## Test plan
- Single job: p=17, a=2, P=Q=(5,1). The bench core returns (6,3) 3 cycles after ec_in_valid, with res_ready high. Required: exactly one ec_in_valid pulse, res_Rx=6, res_Ry=3, res_lat=3, res_timeout=0.
- Backpressure: hold res_ready=0 for 20 cycles. Required: res_* stable throughout, job_ready=0, and no second ec_in_valid.
- Timeout: build with TIMEOUT_CYC=8 and a core that never responds. Required: res_timeout=1, Rx=Ry=0, and res_valid rising 9 cycles after ec_in_valid. A later ec_out_valid sets spurious_err.
- Boundary: with TIMEOUT_CYC=8, ec_out_valid lands exactly on the last WAIT cycle. Required: a normal result with res_lat=8 and res_timeout=0.
- Reset mid-WAIT: assert rst_n=0 asynchronously. Required: res_valid=0, ec_in_valid=0 and job_ready=0 immediately. After release, job_ready=1 one cycle later.
- Build without EC_HOST_LATCNT_EN and rerun the first scenario. Required: res_lat=0 and identical Rx/Ry.
